alu_issue_seq: RTL

- Initiator side of the ALU opcode/func/operand interface: accepts 32-bit MIPS-style instructions over a valid/ready handshake.
- Decodes each instruction, reads operands from an internal register file and drives opcode/func/A/B to the ALU.
- Samples result/zero, writes back, and returns a response over a second valid/ready handshake.
- Sits between the instruction source and the ALU top.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_issue_regfile.sv | 39 +++
 rtl/alu_issue_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue sequencer: opcodes, R-type functs,
// FSM states and instruction field positions.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned FN_MSB  = 5;
    localparam int unsigned FN_LSB  = 0;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: two async read ports, one sync write port, R0 reads zero.
// Indices at or beyond NUM_REGS read zero and drop writes.
module alu_issue_regfile
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 32,
    parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [NUM_REGS];

    // Asynchronous read ports; zero for R0 and out-of-range indices
    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        if (i_raddr_a != 5'd0 && 32'(i_raddr_a) < NUM_REGS) o_rdata_a = r_regs[i_raddr_a];
        if (i_raddr_b != 5'd0 && 32'(i_raddr_b) < NUM_REGS) o_rdata_b = r_regs[i_raddr_b];
    end

    // Synchronous write port with async reset of every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RESET_VAL;
        end else if (i_we && i_waddr != 5'd0 && 32'(i_waddr) < NUM_REGS) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: accepts MIPS-style instructions, translates them into
// R-type ALU operations, writes back the result and returns a response.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 32,
    parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic [4:0]  rsp_rd,
    output logic        rsp_branch_taken,
    output logic        rsp_illegal
);

    state_t      r_state;
    logic [31:0] r_instr;
    logic        r_instr_ready;
    logic [5:0]  r_alu_opcode, r_alu_func;
    logic [31:0] r_alu_a, r_alu_b;
    logic [4:0]  r_dest;
    logic        r_illegal, r_beq;
    logic        r_rsp_valid, r_rsp_zero, r_rsp_taken, r_rsp_illegal;
    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_rd;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm;
    logic [31:0] w_rs_data, w_rt_data;
    logic [5:0]  w_func;
    logic [31:0] w_a, w_b;
    logic [4:0]  w_dest;
    logic        w_illegal, w_beq, w_we;

    assign w_op    = r_instr[OP_MSB:OP_LSB];
    assign w_rs    = r_instr[RS_MSB:RS_LSB];
    assign w_rt    = r_instr[RT_MSB:RT_LSB];
    assign w_rd    = r_instr[RD_MSB:RD_LSB];
    assign w_funct = r_instr[FN_MSB:FN_LSB];
    assign w_imm   = r_instr[IMM_MSB:IMM_LSB];

    assign w_we = (r_state == ST_EXEC) && !r_illegal && (r_dest != 5'd0);

    alu_issue_regfile #(
        .NUM_REGS      (NUM_REGS),
        .REG_RESET_VAL (REG_RESET_VAL)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data),
        .i_we      (w_we),
        .i_waddr   (r_dest),
        .i_wdata   (alu_result)
    );

    // Translate the latched instruction into R-type ALU operands and a destination
    always_comb begin
        w_func    = FN_ADD;
        w_a       = '0;
        w_b       = '0;
        w_dest    = '0;
        w_illegal = 1'b1;
        w_beq     = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                if (w_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                    w_func = w_funct; w_a = w_rs_data; w_b = w_rt_data;
                    w_dest = w_rd; w_illegal = 1'b0;
                end
            end
            OP_ADDI: begin
                w_func = FN_ADD; w_a = w_rs_data; w_b = sext16(w_imm);
                w_dest = w_rt; w_illegal = 1'b0;
            end
            OP_SLTI: begin
                w_func = FN_SLT; w_a = w_rs_data; w_b = sext16(w_imm);
                w_dest = w_rt; w_illegal = 1'b0;
            end
            OP_ANDI: begin
                w_func = FN_AND; w_a = w_rs_data; w_b = zext16(w_imm);
                w_dest = w_rt; w_illegal = 1'b0;
            end
            OP_ORI: begin
                w_func = FN_OR; w_a = w_rs_data; w_b = zext16(w_imm);
                w_dest = w_rt; w_illegal = 1'b0;
            end
            OP_BEQ: begin
                w_func = FN_SUB; w_a = w_rs_data; w_b = w_rt_data;
                w_illegal = 1'b0; w_beq = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_instr_ready <= 1'b1;
            r_alu_opcode  <= '0;
            r_alu_func    <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_dest        <= '0;
            r_illegal     <= 1'b0;
            r_beq         <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_rd      <= '0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_instr       <= instr;
                        r_instr_ready <= 1'b0;
                        r_state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_alu_opcode <= OP_RTYPE;
                    r_alu_func   <= w_func;
                    r_alu_a      <= w_a;
                    r_alu_b      <= w_b;
                    r_dest       <= w_dest;
                    r_illegal    <= w_illegal;
                    r_beq        <= w_beq;
                    r_state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_rsp_data    <= alu_result;
                    r_rsp_zero    <= alu_zero;
                    r_rsp_rd      <= w_we ? r_dest : 5'd0;
                    r_rsp_taken   <= r_beq & alu_zero;
                    r_rsp_illegal <= r_illegal;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_instr_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_instr_ready <= 1'b1;
                    r_rsp_valid   <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready      = r_instr_ready;
    assign alu_opcode       = r_alu_opcode;
    assign alu_func         = r_alu_func;
    assign alu_a            = r_alu_a;
    assign alu_b            = r_alu_b;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign rsp_zero         = r_rsp_zero;
    assign rsp_rd           = r_rsp_rd;
    assign rsp_branch_taken = r_rsp_taken;
    assign rsp_illegal      = r_rsp_illegal;

endmodule
